data_sync_edge_filter: RTL and testbench

//  Multi-channel successor to the single-bit data synchroniser.

---
 rtl/data_sync_edge_filter.sv | 89 ++++++++
 tb/tb_data_sync_edge_filter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_edge_filter.sv
// Multi-channel async-input synchroniser with per-channel glitch filter and rise/fall pulses.
// Define SYNC_EDGE_STICKY_EN to add the event_sticky output and sticky_clr input.
module data_sync_edge_filter #(
    parameter int                 WIDTH         = 8,
    parameter int                 SYNC_STAGE    = 3,
    parameter int                 FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             async_resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
`ifdef SYNC_EDGE_STICKY_EN
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] event_sticky,
    input  logic [WIDTH-1:0] sticky_clr
`else
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] sync_out;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] sync_q;
        logic [CNT_W-1:0] cnt_q;
        logic             dout_q;
        logic             rise_q;
        logic             fall_q;

        // NOTE: the chain keeps its async reset so tools cannot map it into a reset-free shift register.
        always_ff @(posedge clk or negedge async_resetn) begin
            if (!async_resetn) begin
                sync_q <= {SYNC_STAGE{RESET_VAL[i]}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGE-2:0], din[i]};
            end
        end

        assign sync_out[i] = sync_q[SYNC_STAGE-1];

        // The counter tracks consecutive mismatches; any match restarts it, rejecting the glitch.
        always_ff @(posedge clk or negedge async_resetn) begin
            if (!async_resetn) begin
                cnt_q  <= '0;
                dout_q <= RESET_VAL[i];
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync_out[i] == dout_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q  <= '0;
                    dout_q <= sync_out[i];
                    rise_q <= sync_out[i];
                    fall_q <= ~sync_out[i];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign dout[i] = dout_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;

`ifdef SYNC_EDGE_STICKY_EN
        logic sticky_q;

        // A pulse in the same cycle as a clear keeps the flag set.
        always_ff @(posedge clk or negedge async_resetn) begin
            if (!async_resetn) begin
                sticky_q <= 1'b0;
            end else begin
                sticky_q <= (sticky_q & ~sticky_clr[i]) | rise_q | fall_q;
            end
        end

        assign event_sticky[i] = sticky_q;
`endif
    end

endmodule

// File: tb/tb_data_sync_edge_filter.sv
// Self-checking bench for data_sync_edge_filter: directed scenarios plus randomized levels
// compared against a sliding-window reference model.
module tb_data_sync_edge_filter;

    localparam int W    = 8;
    localparam int SYNC = 3;
    localparam int FILT = 4;
    localparam logic [W-1:0] RST_V = '0;

    logic         clk = 1'b0;
    logic         async_resetn = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout, rise, fall;
`ifdef SYNC_EDGE_STICKY_EN
    logic [W-1:0] event_sticky;
    logic [W-1:0] sticky_clr = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    data_sync_edge_filter #(
        .WIDTH(W), .SYNC_STAGE(SYNC), .FILTER_CYCLES(FILT), .RESET_VAL(RST_V)
    ) dut (
        .clk          (clk),
        .async_resetn (async_resetn),
        .din          (din),
        .dout         (dout),
        .rise         (rise),
`ifdef SYNC_EDGE_STICKY_EN
        .fall         (fall),
        .event_sticky (event_sticky),
        .sticky_clr   (sticky_clr)
`else
        .fall         (fall)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the filter input at edge n is din captured SYNC edges earlier;
    // a channel flips when its last FILT filter inputs all disagree with the current level.
    logic [W-1:0] din_hist[$];
    logic [W-1:0] sync_hist[$];
    logic [W-1:0] exp_dout = RST_V;
    logic [W-1:0] exp_rise = '0;
    logic [W-1:0] exp_fall = '0;
    logic [W-1:0] exp_sticky = '0;

    always @(posedge clk or negedge async_resetn) begin
        logic [W-1:0] s;
        logic [W-1:0] nd;
        int           n;
        bit           all_diff;
        if (!async_resetn) begin
            din_hist.delete();
            sync_hist.delete();
            exp_dout   = RST_V;
            exp_rise   = '0;
            exp_fall   = '0;
            exp_sticky = '0;
        end else begin
`ifdef SYNC_EDGE_STICKY_EN
            exp_sticky = (exp_sticky & ~sticky_clr) | exp_rise | exp_fall;
`endif
            n = din_hist.size();
            s = (n >= SYNC) ? din_hist[n-SYNC] : RST_V;
            din_hist.push_back(din);
            sync_hist.push_back(s);
            nd = exp_dout;
            if (sync_hist.size() >= FILT) begin
                for (int c = 0; c < W; c++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < FILT; j++)
                        if (sync_hist[sync_hist.size()-1-j][c] == exp_dout[c]) all_diff = 1'b0;
                    if (all_diff) nd[c] = ~exp_dout[c];
                end
            end
            exp_rise = nd & ~exp_dout;
            exp_fall = ~nd & exp_dout;
            exp_dout = nd;
        end
    end

    task automatic test_reset();
        din = 8'hFF;
        async_resetn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dout, rise, fall} !== {8'h00, 8'h00, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_hold: dout=%h rise=%h fall=%h, want 00/00/00", dout, rise, fall);
            end
        end
        async_resetn = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (dout !== ((k >= 6) ? 8'hFF : 8'h00) || rise !== ((k == 6) ? 8'hFF : 8'h00) || fall !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: dout=%h rise=%h fall=%h", k, dout, rise, fall);
            end
        end
    endtask

    task automatic test_step();
        din = 8'h00;
        repeat (10) @(negedge clk);
        din[0] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (dout !== ((k >= 6) ? 8'h01 : 8'h00) || rise !== ((k == 6) ? 8'h01 : 8'h00) || fall !== 8'h00) begin
                n_fail++;
                $display("FAIL step edge %0d: dout=%h rise=%h fall=%h", k, dout, rise, fall);
            end
        end
    endtask

    task automatic test_glitch();
        int rise_at;
        int fall_at;
        int n_r;
        int n_f;
        din[3] = 1'b1;
        repeat (3) @(negedge clk);
        din[3] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (dout[3] !== 1'b0 || rise[3] !== 1'b0 || fall[3] !== 1'b0 || dout !== exp_dout) begin
                n_fail++;
                $display("FAIL glitch_reject: dout=%h rise=%h fall=%h, want dout %h", dout, rise, fall, exp_dout);
            end
        end
        din[3] = 1'b1;
        rise_at = -1; fall_at = -1; n_r = 0; n_f = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 4) din[3] = 1'b0;
            @(negedge clk);
            if (rise[3] === 1'b1) begin n_r++; rise_at = k; end
            if (fall[3] === 1'b1) begin n_f++; fall_at = k; end
        end
        n_checks++;
        if (n_r != 1 || n_f != 1 || fall_at - rise_at != 4) begin
            n_fail++;
            $display("FAIL pulse4: rises=%0d falls=%0d spacing=%0d, want 1/1/4", n_r, n_f, fall_at - rise_at);
        end
    endtask

    task automatic test_multi_channel();
        int seen;
        din = 8'h00;
        repeat (12) @(negedge clk);
        din = 8'hA5;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rise !== 8'h00) begin
                seen++;
                n_checks++;
                if (rise !== 8'hA5 || fall !== 8'h00) begin
                    n_fail++;
                    $display("FAIL multi_rise: rise=%h fall=%h, want A5/00", rise, fall);
                end
            end
        end
        din = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rise !== 8'h00 || fall !== 8'h00) begin
                seen++;
                n_checks++;
                if (rise !== 8'h5A || fall !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL multi_swap: rise=%h fall=%h, want 5A/A5", rise, fall);
                end
            end
        end
        n_checks++;
        if (seen != 2 || dout !== 8'h5A) begin
            n_fail++;
            $display("FAIL multi_count: pulse cycles=%0d dout=%h, want 2 and 5A", seen, dout);
        end
    endtask

    task automatic test_reset_mid_filter();
        din = 8'h00;
        async_resetn = 1'b0;
        @(negedge clk);
        async_resetn = 1'b1;
        repeat (8) @(negedge clk);
        din[1] = 1'b1;
        repeat (5) @(negedge clk);
        async_resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ($isunknown({dout, rise, fall}) || dout !== 8'h00 || rise !== 8'h00 || fall !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_mid_hold: dout=%h rise=%h fall=%h, want 00/00/00", dout, rise, fall);
            end
        end
        din = 8'h00;
        async_resetn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if ($isunknown({dout, rise, fall}) || dout !== 8'h00 || rise !== 8'h00 || fall !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_mid_after: dout=%h rise=%h fall=%h, want 00/00/00", dout, rise, fall);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int t = 0; t < 80; t++) begin
            din  = W'($urandom);
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                n_checks++;
                if (dout !== exp_dout || rise !== exp_rise || fall !== exp_fall || (rise & fall) !== 8'h00) begin
                    n_fail++;
                    $display("FAIL random: dout=%h rise=%h fall=%h, want %h/%h/%h",
                             dout, rise, fall, exp_dout, exp_rise, exp_fall);
                end
            end
        end
    endtask

`ifdef SYNC_EDGE_STICKY_EN
    task automatic test_sticky();
        int guard;
        din = 8'h00;
        async_resetn = 1'b0;
        @(negedge clk);
        async_resetn = 1'b1;
        repeat (3) @(negedge clk);
        din[2] = 1'b1;
        guard = 0;
        while (rise[2] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        n_checks++;
        if (event_sticky[2] !== 1'b1 || event_sticky !== exp_sticky) begin
            n_fail++;
            $display("FAIL sticky_set: sticky=%h, want %h", event_sticky, exp_sticky);
        end
        din[2] = 1'b0;
        guard = 0;
        while (fall[2] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        sticky_clr[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (event_sticky[2] !== 1'b1 || guard >= 20) begin
            n_fail++;
            $display("FAIL sticky_set_wins: sticky=%h guard=%0d, want bit2 set", event_sticky, guard);
        end
        @(negedge clk);
        sticky_clr[2] = 1'b0;
        n_checks++;
        if (event_sticky[2] !== 1'b0 || event_sticky !== exp_sticky) begin
            n_fail++;
            $display("FAIL sticky_clear: sticky=%h, want %h", event_sticky, exp_sticky);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_multi_channel();
        test_reset_mid_filter();
        test_random();
`ifdef SYNC_EDGE_STICKY_EN
        test_sticky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
